ds_token_streamer: RTL and testbench

Downstream neighbour of flexible_downsampling in the FDViT datapath. Captures the completed HOUT x HOUT x CIN ofmap when the downsampler signals done. Streams the captured map as row-major tokens over a valid/ready interface, LANES channels per beat, to the next transformer stage (patch embedding / token mixer). Decouples the downsampler's whole-array output from the narrow streaming input of the next stage and absorbs backpressure.

---
 rtl/ds_pkg.sv | 31 +++
 rtl/ds_token_streamer_if.sv | 43 ++++
 rtl/ds_beat_counter.sv | 73 +++++++
 rtl/ds_token_streamer.sv | 128 ++++++++++++
 tb/tb_ds_token_streamer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/ds_pkg.sv
// ds_pkg
// Shared definitions for the FDViT downsampling slice (flexible_downsampling
// and its downstream ds_token_streamer).
//   - default geometry: CIN channels, HOUT x HOUT map, LANES channels per beat
//   - derived beat/token counts and index widths
//   - streamer FSM state type
//   - cnt_w(): counter width helper that never returns zero
package ds_pkg;

  localparam int CIN_DEF   = 64;
  localparam int HOUT_DEF  = 19;
  localparam int LANES_DEF = 8;

  // Beats per token and beats per complete frame at the default geometry.
  localparam int GPT             = CIN_DEF / LANES_DEF;
  localparam int BEATS_PER_FRAME = HOUT_DEF * HOUT_DEF * GPT;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } ds_state_e;

  // Width of an index spanning 0..n-1; a 1-entry range still gets one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int TIDX_W_DEF = cnt_w(HOUT_DEF * HOUT_DEF);

endpackage

// File: rtl/ds_token_streamer_if.sv
// ds_token_streamer_if
// Valid/ready token stream from ds_token_streamer to the next transformer
// stage.
//   m_valid      beat valid (producer)
//   m_ready      consumer ready
//   m_data       LANES bytes, byte k = channel grp*LANES+k
//   m_last_beat  last beat of the current token
//   m_last       last beat of the frame
//   m_token_idx  row*HOUT+col of the current beat
// Modports: master (producer side), slave (consumer side).
interface ds_token_streamer_if
  import ds_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int TIDX_W = TIDX_W_DEF
) ();

  logic                  m_valid;
  logic                  m_ready;
  logic [LANES*8-1:0]    m_data;
  logic                  m_last_beat;
  logic                  m_last;
  logic [TIDX_W-1:0]     m_token_idx;

  modport master (
    output m_valid,
    output m_data,
    output m_last_beat,
    output m_last,
    output m_token_idx,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last_beat,
    input  m_last,
    input  m_token_idx,
    output m_ready
  );

endinterface

// File: rtl/ds_beat_counter.sv
// ds_beat_counter
// Nested grp -> col -> row beat counter for the token streamer, plus a running
// token index (row*HOUT+col) kept as its own counter so no multiply is needed.
//   clk, rst     clock, synchronous active-high reset
//   clr          return all counters to beat 0 (frame start)
//   en           advance by one beat (stream handshake)
//   row_nxt/col_nxt/grp_nxt  indices of the beat after the current one
//   tidx         token index of the current beat
//   last_beat    current beat is the last of its token
//   last         current beat is the last of the frame
module ds_beat_counter #(
  parameter int HOUT   = 19,
  parameter int GPT    = 8,
  parameter int ROW_W  = 5,
  parameter int GRP_W  = 3,
  parameter int TIDX_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [ROW_W-1:0]  row_nxt,
  output logic [ROW_W-1:0]  col_nxt,
  output logic [GRP_W-1:0]  grp_nxt,
  output logic [TIDX_W-1:0] tidx,
  output logic              last_beat,
  output logic              last
);

  localparam logic [GRP_W-1:0] GRP_MAX = GRP_W'(GPT - 1);
  localparam logic [ROW_W-1:0] POS_MAX = ROW_W'(HOUT - 1);

  logic [ROW_W-1:0]  row;
  logic [ROW_W-1:0]  col;
  logic [GRP_W-1:0]  grp;
  logic [TIDX_W-1:0] tidx_nxt;
  logic              col_wrap;
  logic              row_wrap;

  always_comb begin
    last_beat = (grp == GRP_MAX);
    col_wrap  = (col == POS_MAX);
    row_wrap  = (row == POS_MAX);
    last      = last_beat && col_wrap && row_wrap;

    grp_nxt  = last_beat ? '0 : grp + 1'b1;
    col_nxt  = col;
    row_nxt  = row;
    tidx_nxt = tidx;
    if (last_beat) begin
      col_nxt  = col_wrap ? '0 : col + 1'b1;
      tidx_nxt = last ? '0 : tidx + 1'b1;
      if (col_wrap) begin
        row_nxt = row_wrap ? '0 : row + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      row  <= '0;
      col  <= '0;
      grp  <= '0;
      tidx <= '0;
    end else if (en) begin
      row  <= row_nxt;
      col  <= col_nxt;
      grp  <= grp_nxt;
      tidx <= tidx_nxt;
    end
  end

endmodule

// File: rtl/ds_token_streamer.sv
// ds_token_streamer
// Captures the HOUT x HOUT x CIN ofmap of flexible_downsampling when start
// pulses, then streams it row-major as tokens, LANES channels per beat, over a
// valid/ready interface that tolerates arbitrary backpressure.
//   clk, rst  clock, synchronous active-high reset (aborts a frame)
//   start     capture request, honoured only while idle
//   ofmap     downsampled map, sampled on an accepted start
//   busy      high while a frame is being streamed
//   done      one-cycle pulse after the final beat handshake
//   m_if      token stream (master modport)
module ds_token_streamer
  import ds_pkg::*;
#(
  parameter int CIN   = CIN_DEF,
  parameter int HOUT  = HOUT_DEF,
  parameter int LANES = LANES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] ofmap [0:HOUT-1][0:HOUT-1][0:CIN-1],
  output logic       busy,
  output logic       done,
  ds_token_streamer_if.master m_if
);

  localparam int BEATS_PER_TOKEN = CIN / LANES;
  localparam int ROW_W  = cnt_w(HOUT);
  localparam int GRP_W  = cnt_w(BEATS_PER_TOKEN);
  localparam int CH_W   = cnt_w(CIN);
  localparam int TIDX_W = cnt_w(HOUT * HOUT);

  if (CIN % LANES != 0) begin : g_bad_cin
    $error("ds_token_streamer: CIN (%0d) must be a multiple of LANES (%0d)", CIN, LANES);
  end

  ds_state_e          state;
  logic [7:0]         cap [0:HOUT-1][0:HOUT-1][0:CIN-1];
  logic [LANES*8-1:0] beat_p1;
  logic [LANES*8-1:0] beat_nxt;
  logic [LANES*8-1:0] beat_first;
  logic               accept;
  logic               hs;
  logic [ROW_W-1:0]   row_nxt;
  logic [ROW_W-1:0]   col_nxt;
  logic [GRP_W-1:0]   grp_nxt;
  logic [TIDX_W-1:0]  tidx;
  logic               cnt_last_beat;
  logic               cnt_last;

  // Reset has priority over a coincident start.
  assign accept = (state == IDLE) && start && !rst;
  assign hs     = (state == STREAM) && m_if.m_ready;

  ds_beat_counter #(
    .HOUT   (HOUT),
    .GPT    (BEATS_PER_TOKEN),
    .ROW_W  (ROW_W),
    .GRP_W  (GRP_W),
    .TIDX_W (TIDX_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .en        (hs),
    .row_nxt   (row_nxt),
    .col_nxt   (col_nxt),
    .grp_nxt   (grp_nxt),
    .tidx      (tidx),
    .last_beat (cnt_last_beat),
    .last      (cnt_last)
  );

  // Beat 0 comes straight from ofmap because the capture buffer is being
  // written on the same edge; later beats come from the buffer.
  always_comb begin
    beat_nxt   = '0;
    beat_first = '0;
    for (int k = 0; k < LANES; k++) begin
      beat_nxt[k*8 +: 8]   = cap[row_nxt][col_nxt][CH_W'(int'(grp_nxt) * LANES + k)];
      beat_first[k*8 +: 8] = ofmap[0][0][CH_W'(k)];
    end
  end

  // ---- capture stage: whole-map snapshot, data only, no reset ----
  always_ff @(posedge clk) begin
    if (accept) begin
      cap <= ofmap;
    end
  end

  // ---- output stage: FSM and registered beat ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      beat_p1 <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= STREAM;
            beat_p1 <= beat_first;
          end
        end
        STREAM: begin
          if (hs) begin
            if (cnt_last) begin
              state <= DONE;
            end else begin
              beat_p1 <= beat_nxt;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy             = (state == STREAM);
  assign done             = (state == DONE);
  assign m_if.m_valid     = (state == STREAM);
  assign m_if.m_data      = beat_p1;
  assign m_if.m_last_beat = (state == STREAM) && cnt_last_beat;
  assign m_if.m_last      = (state == STREAM) && cnt_last;
  assign m_if.m_token_idx = tidx;

endmodule

// File: tb/tb_ds_token_streamer.sv
// tb_ds_token_streamer
// Directed bench for ds_token_streamer at default geometry (CIN=64, HOUT=19,
// LANES=8). ofmap[i][j][c] = (i*19 + j + c) % 256; expected beats are derived
// from that formula by the bench.
module tb_ds_token_streamer;

  localparam int CIN   = 64;
  localparam int HOUT  = 19;
  localparam int LANES = 8;
  localparam int GPT   = CIN / LANES;
  localparam int BEATS = HOUT * HOUT * GPT;
  localparam int TW    = 9;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] ofmap [0:HOUT-1][0:HOUT-1][0:CIN-1];
  logic       busy;
  logic       done;

  ds_token_streamer_if #(.LANES(LANES), .TIDX_W(TW)) sif ();

  ds_token_streamer #(
    .CIN   (CIN),
    .HOUT  (HOUT),
    .LANES (LANES)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .ofmap (ofmap),
    .busy  (busy),
    .done  (done),
    .m_if  (sif.master)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [7:0] x);
    for (int i = 0; i < HOUT; i++)
      for (int j = 0; j < HOUT; j++)
        for (int c = 0; c < CIN; c++)
          ofmap[i][j][c] = 8'((i * 19 + j + c) % 256) ^ x;
  endtask

  function automatic logic [63:0] exp_data(input int n);
    int row, col, g;
    logic [63:0] d;
    row = n / (HOUT * GPT);
    col = (n / GPT) % HOUT;
    g   = n % GPT;
    d   = '0;
    for (int k = 0; k < LANES; k++)
      d[k*8 +: 8] = 8'((row * 19 + col + g * LANES + k) % 256);
    return d;
  endfunction

  task automatic start_frame();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Runs one frame from the cycle after start. mode 0: ready always high,
  // mode 1: ready high on odd cycles. inj_at: re-pulse start with altered
  // ofmap when that many beats are done. abort_at: return (at a negedge)
  // once that many beats are done. done_cyc = cycle of the done pulse.
  task automatic stream(input int mode, input int inj_at, input int abort_at,
                        output int done_cyc, output int nbeats);
    int          cyc  = 1;
    int          n    = 0;
    bit          held = 1'b0;
    bit          fin  = 1'b0;
    bit          injd = 1'b0;
    logic [63:0] hd;
    logic [63:0] ht;
    done_cyc = -1;
    while (!fin && cyc < 7000) begin
      sif.m_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 1);
      @(negedge clk);
      if (held) begin
        chk("hold_data", sif.m_data, hd);
        chk("hold_tidx", 64'(sif.m_token_idx), ht);
        held = 1'b0;
      end
      if (done) begin
        chk("done_beats", 64'(n), 64'(BEATS));
        chk("done_valid", 64'(sif.m_valid), 64'd0);
        chk("done_busy", 64'(busy), 64'd0);
        done_cyc = cyc;
        fin = 1'b1;
      end else if (abort_at >= 0 && n == abort_at) begin
        fin = 1'b1;
      end else begin
        chk("valid", 64'(sif.m_valid), 64'd1);
        chk("busy", 64'(busy), 64'd1);
        if (sif.m_valid && sif.m_ready) begin
          chk("data", sif.m_data, exp_data(n));
          chk("tidx", 64'(sif.m_token_idx), 64'(n / GPT));
          chk("last_beat", 64'(sif.m_last_beat), 64'((n % GPT) == GPT - 1));
          chk("last", 64'(sif.m_last), 64'(n == BEATS - 1));
          if (n == 0) chk("beat0_const", sif.m_data, 64'h0706050403020100);
          if (n == 161) chk("tok20_g1_const", sif.m_data, 64'h232221201F1E1D1C);
          if (n == BEATS - 1) chk("last_tidx_const", 64'(sif.m_token_idx), 64'd360);
          n++;
        end else if (sif.m_valid) begin
          held = 1'b1;
          hd   = sif.m_data;
          ht   = 64'(sif.m_token_idx);
        end
        if (inj_at >= 0 && n == inj_at && !injd) begin
          fill(8'hFF);
          start = 1'b1;
          injd  = 1'b1;
        end
      end
      if (!fin) begin
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc++;
      end
    end
    if (!fin) chk("timeout", 64'd0, 64'd1);
    nbeats = n;
  endtask

  initial begin
    int d;
    int n;
    rst         = 1'b1;
    start       = 1'b0;
    sif.m_ready = 1'b0;
    fill(8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(sif.m_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_data", sif.m_data, 64'd0);
    chk("rst_tidx", 64'(sif.m_token_idx), 64'd0);
    chk("rst_last", 64'({sif.m_last, sif.m_last_beat}), 64'd0);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    sif.m_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready_valid", 64'(sif.m_valid), 64'd0);
    end

    // Full frame, ready held high.
    start_frame();
    stream(0, -1, -1, d, n);
    chk("s2_done_cycle", 64'(d), 64'd2889);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("done_once", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    // Back-to-back: start in the first idle cycle after done, toggling ready.
    start_frame();
    stream(1, -1, -1, d, n);
    chk("s3_done_cycle", 64'(d), 64'd5776);

    // Start re-pulsed mid-frame with a different map must be ignored.
    @(posedge clk);
    #1;
    start_frame();
    stream(0, 100, -1, d, n);
    chk("s4_done_cycle", 64'(d), 64'd2889);
    fill(8'h00);

    // Abort with rst at beat 500, then restart from beat 0.
    @(posedge clk);
    #1;
    start_frame();
    stream(0, -1, 500, d, n);
    chk("s5_abort_beats", 64'(n), 64'd500);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_valid", 64'(sif.m_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_tidx", 64'(sif.m_token_idx), 64'd0);
    chk("abort_data", sif.m_data, 64'd0);
    repeat (3) begin
      chk("abort_no_done", 64'(done), 64'd0);
      @(negedge clk);
    end
    start_frame();
    stream(0, -1, -1, d, n);
    chk("s5_restart_done_cycle", 64'(d), 64'd2889);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
